beat_scheduler: RTL and testbench
=================================

Name: beat_scheduler

Overview:
- Sequences the beat-storage model and shares its single write port between two requesters: button-matrix edits and pitch-encoder edits.
- Generates the playback beat index consumed by the audio controller from a programmable step period.
- Provides a clear-all sweep that writes pitch 0 to every beat.
- Sits between the button/encoder controllers and the model; replaces the ad-hoc write and beat-count logic at top level.

Parameters:
- NUM_BEATS, 16, number of sequencer steps; must be a power of two; BEAT_W = $clog2(NUM_BEATS).
- PITCH_W, 3, pitch field width; write word width WR_W = PITCH_W + BEAT_W (7 by default).
- PERIOD_W, 24, width of the step-period counter.
- DEFAULT_PERIOD, 3_000_000, step period used out of reset (clk cycles; 250 ms at 12 MHz).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; rst_n is asynchronous and active-low.
- run  in  1  1 = playback advancing; 0 = paused.
- restart  in  1  single-cycle pulse; returns playback to beat 0.
- step_period  in  PERIOD_W  requested clk cycles per step.
- btn_valid  in  1  button write request.
- btn_data  in  WR_W  button write word, {pitch, index}.
- btn_ready  out  1  button request accepted this cycle.
- enc_valid  in  1  encoder write request.
- enc_data  in  WR_W  encoder write word.
- enc_ready  out  1  encoder request accepted this cycle.
- clear_req  in  1  start clear-all sweep.
- clear_busy  out  1  sweep in progress.
- wr_en  out  1  model write strobe.
- wr_data  out  WR_W  model write word; [WR_W-1:BEAT_W] = pitch, [BEAT_W-1:0] = index.
- beat_count  out  BEAT_W  current playback beat.
- step_pulse  out  1  one-cycle pulse coincident with each beat_count change.

Behaviour:
- Reset values:
  - All outputs 0: wr_en, wr_data, beat_count, step_pulse, clear_busy, btn_ready, enc_ready.
  - period_q = DEFAULT_PERIOD, tick_cnt = 0, FSM in IDLE, last_grant = ENC (so the button wins the first tie).
- Step timer:
  - While run = 1, tick_cnt increments each cycle.
  - When tick_cnt == period_q - 1: tick_cnt <= 0, beat_count <= beat_count + 1 (NUM_BEATS-1 wraps to 0), step_pulse = 1 for that registered cycle, and period_q <= step_period.
  - step_period < 2 is clamped to 2.
- Run/pause/restart:
  - run = 0 holds tick_cnt and beat_count.
  - A rising edge of run clears tick_cnt and reloads period_q; beat_count resumes from its held value.
  - restart: tick_cnt <= 0, beat_count <= 0, period_q reloads, no step_pulse. restart beats a coincident step boundary.
- Arbitration (FSM state IDLE):
  - btn_ready and enc_ready are combinational. Both are 0 when clear_req = 1 or the state is not IDLE.
  - Only one requester is valid: that requester gets ready = 1.
  - Both are valid: the requester that is not last_grant gets ready (round-robin); last_grant updates on each handshake.
  - Handshake (valid & ready): wr_en = 1 and wr_data = granted data on the next cycle (latency 1). At most one write per cycle.
  - Unaccepted valid must hold until ready.
- Clear sweep:
  - clear_req = 1 in IDLE -> CLEAR next cycle, clr_idx = 0, clear_busy = 1.
  - In CLEAR, each cycle: wr_en = 1, wr_data = {0, clr_idx}, clr_idx++.
  - After index NUM_BEATS-1 is written -> IDLE. This gives NUM_BEATS consecutive write cycles.
  - clear_busy is high for exactly those NUM_BEATS cycles.
  - clear_req in CLEAR is ignored (no re-trigger).
  - The step timer keeps running during CLEAR.
- FSM states: IDLE, CLEAR only. The write pipeline register is outside the FSM.
- Reset mid-sweep: immediate abort; all state goes to reset values; no further writes.

Decomposition:
- Package seq_pkg holds:
  - NUM_BEATS, BEAT_W, PITCH_W, WR_W constants.
  - typedef wr_word_t, a packed struct {pitch, index}.
  - typedef enum sched_state_t {IDLE, CLEAR}.
  - enum grant_t {BTN, ENC}.
- One sub-module, step_timer: tick_cnt, period_q, clamp, run-edge and restart handling; outputs beat_count and step_pulse.
- Arbitration and the clear FSM stay in beat_scheduler.

Test Plan:
- step_period = 4, run = 1 from reset -> beat_count 0→1 after 4 cycles; step_pulse every 4th cycle; wraps 15→0 after 64 cycles.
- Mid-run, step_period changes 4→8 -> the current step still completes at 4 cycles; the next step takes 8 cycles. Driving step_period = 0 -> steps every 2 cycles.
- btn_valid and enc_valid both held high with btn_data = 7'h15 and enc_data = 7'h2A -> wr_data alternates 15, 2A, 15, ... one write per cycle, button first.
- clear_req pulse while btn_valid is high -> btn_ready = 0 for NUM_BEATS + 1 cycles; wr_data = 00..0F on 16 consecutive cycles; the button write follows on the cycle after clear_busy drops.
- run dropped at beat 5, mid-step, then raised -> beat_count holds at 5; the next advance to 6 occurs one full period after run rises. A restart pulse coincident with a step boundary -> beat_count = 0, no step_pulse.
- rst_n asserted during CLEAR at clr_idx = 7 -> wr_en, clear_busy and beat_count go to 0 immediately; after release, beats advance from 0 and the first tie is granted to the button.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants and types for the beat sequencer: beat/pitch widths,
// the model write word layout, scheduler FSM states and arbiter grant IDs.
package seq_pkg;

    localparam int NUM_BEATS = 16;
    localparam int BEAT_W    = $clog2(NUM_BEATS);
    localparam int PITCH_W   = 3;
    localparam int WR_W      = PITCH_W + BEAT_W;

    // Model write word: pitch in the upper bits, beat index in the lower bits.
    typedef struct packed {
        logic [PITCH_W-1:0] pitch;
        logic [BEAT_W-1:0]  index;
    } wr_word_t;

    typedef enum logic {IDLE, CLEAR} sched_state_t;

    typedef enum logic {BTN, ENC} grant_t;

endpackage

// File: rtl/step_timer.sv
// Playback step timer: counts clk cycles per step, advances the beat index
// and emits a one-cycle step pulse alongside each beat change. The step
// period is only picked up at step boundaries, run rising edges and restart,
// so a period change never truncates the step in progress.
module step_timer
    import seq_pkg::*;
#(
    parameter int PERIOD_W       = 24,
    parameter int DEFAULT_PERIOD = 3_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                restart,
    input  logic [PERIOD_W-1:0] step_period,
    output logic [BEAT_W-1:0]   beat_count,
    output logic                step_pulse
);

    logic [PERIOD_W-1:0] tick_cnt;
    logic [PERIOD_W-1:0] period_q;
    logic                run_q;
    logic                run_rise;
    logic                at_boundary;

    // Periods below 2 would make the boundary compare degenerate; floor at 2.
    function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
        return (p < PERIOD_W'(2)) ? PERIOD_W'(2) : p;
    endfunction

    assign run_rise    = run & ~run_q;
    assign at_boundary = run && (tick_cnt == period_q - PERIOD_W'(1));

    // Tick counter, beat index and period reload; restart outranks a boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt   <= '0;
            period_q   <= PERIOD_W'(DEFAULT_PERIOD);
            run_q      <= 1'b0;
            beat_count <= '0;
            step_pulse <= 1'b0;
        end else begin
            run_q      <= run;
            step_pulse <= 1'b0;
            if (restart) begin
                tick_cnt   <= '0;
                beat_count <= '0;
                period_q   <= clamp_period(step_period);
            end else if (run_rise) begin
                tick_cnt <= '0;
                period_q <= clamp_period(step_period);
            end else if (at_boundary) begin
                tick_cnt   <= '0;
                beat_count <= beat_count + BEAT_W'(1);
                step_pulse <= 1'b1;
                period_q   <= clamp_period(step_period);
            end else if (run) begin
                tick_cnt <= tick_cnt + PERIOD_W'(1);
            end
        end
    end

endmodule

// File: rtl/beat_scheduler.sv
// Beat scheduler: owns the model's single write port, arbitrating button
// and encoder edits round-robin, and runs a clear-all sweep that writes
// pitch 0 to every beat. Also hosts the playback step timer.
module beat_scheduler
    import seq_pkg::*;
#(
    parameter int PERIOD_W       = 24,
    parameter int DEFAULT_PERIOD = 3_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                restart,
    input  logic [PERIOD_W-1:0] step_period,
    input  logic                btn_valid,
    input  logic [WR_W-1:0]     btn_data,
    output logic                btn_ready,
    input  logic                enc_valid,
    input  logic [WR_W-1:0]     enc_data,
    output logic                enc_ready,
    input  logic                clear_req,
    output logic                clear_busy,
    output logic                wr_en,
    output logic [WR_W-1:0]     wr_data,
    output logic [BEAT_W-1:0]   beat_count,
    output logic                step_pulse
);

    sched_state_t     state;
    sched_state_t     state_nxt;
    grant_t           last_grant;
    logic [BEAT_W-1:0] clr_idx;
    wr_word_t         wr_q;
    logic             arb_open;
    logic             btn_hs;
    logic             enc_hs;

    step_timer #(
        .PERIOD_W       (PERIOD_W),
        .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_step_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .restart     (restart),
        .step_period (step_period),
        .beat_count  (beat_count),
        .step_pulse  (step_pulse)
    );

    assign btn_hs  = btn_valid & btn_ready;
    assign enc_hs  = enc_valid & enc_ready;
    assign wr_data = wr_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state: a sweep runs until the last beat index has been issued.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clear_req) state_nxt = CLEAR;
            CLEAR:   if (clr_idx == BEAT_W'(NUM_BEATS - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: grants only while idle with no pending clear; the
    // requester that did not win last time takes a tie.
    always_comb begin
        arb_open   = rst_n && (state == IDLE) && !clear_req;
        btn_ready  = arb_open && btn_valid && (!enc_valid || last_grant == ENC);
        enc_ready  = arb_open && enc_valid && (!btn_valid || last_grant == BTN);
        clear_busy = (state == CLEAR);
    end

    // Round-robin memory, updated on every accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      last_grant <= ENC;
        else if (btn_hs) last_grant <= BTN;
        else if (enc_hs) last_grant <= ENC;
    end

    // Sweep index: parked at 0 while idle, walks every beat during CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              clr_idx <= '0;
        else if (state == CLEAR) clr_idx <= clr_idx + BEAT_W'(1);
        else                     clr_idx <= '0;
    end

    // Write pipeline register: one model write per cycle, one cycle after issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en <= 1'b0;
            wr_q  <= '0;
        end else begin
            wr_en <= 1'b0;
            if (state == CLEAR) begin
                wr_en <= 1'b1;
                wr_q  <= wr_word_t'{pitch: '0, index: clr_idx};
            end else if (btn_hs) begin
                wr_en <= 1'b1;
                wr_q  <= wr_word_t'(btn_data);
            end else if (enc_hs) begin
                wr_en <= 1'b1;
                wr_q  <= wr_word_t'(enc_data);
            end
        end
    end

endmodule

// File: tb/tb_beat_scheduler.sv
// Directed bench for beat_scheduler: step timing, period changes and clamp,
// pause/restart, round-robin writes, clear sweep and reset mid-sweep.
module tb_beat_scheduler;
    import seq_pkg::*;

    localparam int PERIOD_W = 24;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                run;
    logic                restart;
    logic [PERIOD_W-1:0] step_period;
    logic                btn_valid;
    logic [WR_W-1:0]     btn_data;
    logic                btn_ready;
    logic                enc_valid;
    logic [WR_W-1:0]     enc_data;
    logic                enc_ready;
    logic                clear_req;
    logic                clear_busy;
    logic                wr_en;
    logic [WR_W-1:0]     wr_data;
    logic [BEAT_W-1:0]   beat_count;
    logic                step_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    beat_scheduler #(
        .PERIOD_W       (PERIOD_W),
        .DEFAULT_PERIOD (3_000_000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .restart     (restart),
        .step_period (step_period),
        .btn_valid   (btn_valid),
        .btn_data    (btn_data),
        .btn_ready   (btn_ready),
        .enc_valid   (enc_valid),
        .enc_data    (enc_data),
        .enc_ready   (enc_ready),
        .clear_req   (clear_req),
        .clear_busy  (clear_busy),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .beat_count  (beat_count),
        .step_pulse  (step_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        run         = 1'b1;
        restart     = 1'b0;
        step_period = 24'd4;
        btn_valid   = 1'b0;
        btn_data    = '0;
        enc_valid   = 1'b0;
        enc_data    = '0;
        clear_req   = 1'b0;
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_beat", beat_count, 0);
        check("rst_pulse", step_pulse, 0);
        check("rst_busy", clear_busy, 0);
        check("rst_btn_ready", btn_ready, 0);
        check("rst_enc_ready", enc_ready, 0);
        step(2);
        rst_n = 1'b1;

        // Period 4 from reset: E0 sees run rise, beat 1 at E4, wrap at E64.
        step(1);
        check("e0_beat", beat_count, 0);
        step(3);
        check("e3_beat", beat_count, 0);
        check("e3_pulse", step_pulse, 0);
        step(1);
        check("e4_beat", beat_count, 1);
        check("e4_pulse", step_pulse, 1);
        step(1);
        check("e5_pulse", step_pulse, 0);
        step(58);
        check("e63_beat", beat_count, 15);
        step(1);
        check("wrap_beat", beat_count, 0);
        check("wrap_pulse", step_pulse, 1);

        // Period 4 -> 8: current step keeps 4, next takes 8.
        step_period = 24'd8;
        step(3);
        check("p4_hold_beat", beat_count, 0);
        step(1);
        check("p4_end_beat", beat_count, 1);
        check("p4_end_pulse", step_pulse, 1);
        step(7);
        check("p8_hold_beat", beat_count, 1);
        step(1);
        check("p8_end_beat", beat_count, 2);
        // Period 0 clamps to 2 after the already-loaded 8-cycle step.
        step_period = 24'd0;
        step(8);
        check("p8b_beat", beat_count, 3);
        step(1);
        check("clamp_mid_beat", beat_count, 3);
        check("clamp_mid_pulse", step_pulse, 0);
        step(1);
        check("clamp_beat4", beat_count, 4);
        check("clamp_pulse4", step_pulse, 1);
        step(2);
        check("clamp_beat5", beat_count, 5);

        // Pause mid-step at beat 5, then resume with period 4.
        run = 1'b0;
        step_period = 24'd4;
        step(5);
        check("pause_beat", beat_count, 5);
        check("pause_pulse", step_pulse, 0);
        run = 1'b1;
        step(4);
        check("resume_hold_beat", beat_count, 5);
        step(1);
        check("resume_beat", beat_count, 6);
        check("resume_pulse", step_pulse, 1);
        // Restart coincident with the next boundary.
        step(3);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check("restart_beat", beat_count, 0);
        check("restart_pulse", step_pulse, 0);
        step(4);
        check("post_restart_beat", beat_count, 1);
        check("post_restart_pulse", step_pulse, 1);

        // Round-robin with both requesters held valid.
        btn_valid = 1'b1; btn_data = 7'h15;
        enc_valid = 1'b1; enc_data = 7'h2A;
        #1;
        check("rr_btn_ready0", btn_ready, 1);
        check("rr_enc_ready0", enc_ready, 0);
        step(1);
        check("rr_wr_en1", wr_en, 1);
        check("rr_wr1", wr_data, 7'h15);
        check("rr_enc_ready1", enc_ready, 1);
        check("rr_btn_ready1", btn_ready, 0);
        step(1);
        check("rr_wr2", wr_data, 7'h2A);
        step(1);
        check("rr_wr3", wr_data, 7'h15);
        step(1);
        check("rr_wr4", wr_data, 7'h2A);
        check("rr_wr_en4", wr_en, 1);
        btn_valid = 1'b0;
        enc_valid = 1'b0;
        step(1);
        check("rr_idle_wr_en", wr_en, 0);

        // Clear sweep while a button request waits; re-pulse is ignored.
        btn_valid = 1'b1; btn_data = 7'h33;
        clear_req = 1'b1;
        #1;
        check("clr_req_btn_ready", btn_ready, 0);
        for (int i = 1; i <= 17; i++) begin
            step(1);
            clear_req = (i == 5);
            #1;
            if (i <= 16) begin
                check("clr_busy", clear_busy, 1);
                check("clr_btn_ready", btn_ready, 0);
            end
            if (i >= 2) begin
                check("clr_wr_en", wr_en, 1);
                check("clr_wr_data", wr_data, i - 2);
            end
        end
        check("clr_done_busy", clear_busy, 0);
        check("clr_done_btn_ready", btn_ready, 1);
        step(1);
        check("clr_btn_wr_en", wr_en, 1);
        check("clr_btn_wr", wr_data, 7'h33);
        btn_valid = 1'b0;
        step(1);
        check("clr_no_retrigger_busy", clear_busy, 0);
        check("clr_no_retrigger_wr_en", wr_en, 0);

        // Reset in the middle of a sweep at clr_idx 7.
        clear_req = 1'b1;
        step(1);
        clear_req = 1'b0;
        step(7);
        check("mid_busy", clear_busy, 1);
        check("mid_wr_data", wr_data, 6);
        rst_n = 1'b0;
        btn_valid = 1'b1; btn_data = 7'h15;
        enc_valid = 1'b1; enc_data = 7'h2A;
        #1;
        check("abort_wr_en", wr_en, 0);
        check("abort_busy", clear_busy, 0);
        check("abort_beat", beat_count, 0);
        check("abort_btn_ready", btn_ready, 0);
        step(2);
        check("abort_hold_wr_en", wr_en, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_btn_ready", btn_ready, 1);
        check("post_rst_enc_ready", enc_ready, 0);
        step(1);
        check("post_rst_wr1", wr_data, 7'h15);
        check("post_rst_wr_en1", wr_en, 1);
        step(1);
        check("post_rst_wr2", wr_data, 7'h2A);
        btn_valid = 1'b0;
        enc_valid = 1'b0;
        step(2);
        check("post_rst_beat0", beat_count, 0);
        check("post_rst_wr_en_idle", wr_en, 0);
        step(1);
        check("post_rst_beat1", beat_count, 1);
        check("post_rst_pulse1", step_pulse, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
